// File: rtl/snake_pkg.sv
// Shared snake-game definitions: playfield geometry, cell coordinates and
// the food placer state encoding.
package snake_pkg;

    localparam int unsigned GRID_W    = 64;
    localparam int unsigned GRID_H    = 48;
    localparam int unsigned COL_BITS  = 6;
    localparam int unsigned ROW_BITS  = 6;
    localparam int unsigned MAX_TRIES = 16;

    typedef struct packed {
        logic [COL_BITS-1:0] col;
        logic [ROW_BITS-1:0] row;
    } coord_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_QUERY  = 3'd3,
        ST_COMMIT = 3'd4,
        ST_FAIL   = 3'd5
    } fp_state_e;

endpackage

// File: rtl/food_placer.sv
// Picks a free, in-range food cell from the random coordinate words, querying
// the snake-body logic for occupancy and retrying up to MAX_TRIES samples.
module food_placer
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W    = snake_pkg::GRID_W,
    parameter int unsigned GRID_H    = snake_pkg::GRID_H,
    parameter int unsigned MAX_TRIES = snake_pkg::MAX_TRIES
) (
    input  logic                clk1,
    input  logic                rst1_n,
    input  logic                place_req,
    input  logic [9:0]          rnd_x,
    input  logic [9:0]          rnd_y,
    output logic                occ_req,
    output logic [COL_BITS-1:0] occ_x,
    output logic [ROW_BITS-1:0] occ_y,
    input  logic                occ_ack,
    input  logic                occ_hit,
    output logic [COL_BITS-1:0] food_x,
    output logic [ROW_BITS-1:0] food_y,
    output logic                food_valid,
    output logic                place_done,
    output logic                place_fail,
    output logic                busy
);

    localparam int unsigned TRY_BITS = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_BITS-1:0] TRY_LIMIT = TRY_BITS'(MAX_TRIES);
    localparam logic [TRY_BITS-1:0] TRY_ONE   = TRY_BITS'(1);
    localparam logic [TRY_BITS-1:0] TRY_ZERO  = TRY_BITS'(0);

    fp_state_e             state_q, state_d;
    logic [TRY_BITS-1:0]   tries_q, tries_d;
    coord_t                cand_q, cand_d;
    coord_t                occ_q, occ_d;
    coord_t                food_q, food_d;
    logic                  occ_req_q, occ_req_d;
    logic                  food_valid_q, food_valid_d;
    logic                  place_done_q, place_done_d;
    logic                  place_fail_q, place_fail_d;
    logic                  busy_q, busy_d;
    logic                  out_of_range_s;
    logic                  tries_left_s;
    logic                  unused_rnd_s;

    // Upper random bits are discarded by the range reduction.
    assign unused_rnd_s = ^{rnd_x[9:COL_BITS], rnd_y[9:ROW_BITS]};

    assign out_of_range_s = (32'(cand_q.col) >= GRID_W) || (32'(cand_q.row) >= GRID_H);
    assign tries_left_s   = (tries_q < TRY_LIMIT);

    // Next-state and output computation for the placement FSM.
    always_comb begin
        state_d      = state_q;
        tries_d      = tries_q;
        cand_d       = cand_q;
        occ_d        = occ_q;
        food_d       = food_q;
        occ_req_d    = occ_req_q;
        food_valid_d = food_valid_q;
        place_done_d = 1'b0;
        place_fail_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (place_req) begin
                    tries_d = TRY_ZERO;
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                cand_d.col = rnd_x[COL_BITS-1:0];
                cand_d.row = rnd_y[ROW_BITS-1:0];
                if (tries_q != TRY_LIMIT) begin
                    tries_d = tries_q + TRY_ONE;
                end else begin
                    tries_d = tries_q;
                end
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (out_of_range_s) begin
                    if (tries_left_s) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        place_fail_d = 1'b1;
                        state_d      = ST_FAIL;
                    end
                end else begin
                    occ_req_d = 1'b1;
                    occ_d     = cand_q;
                    state_d   = ST_QUERY;
                end
            end
            ST_QUERY: begin
                // Outputs for COMMIT/FAIL are loaded here so they are valid
                // during the one cycle spent in those states.
                if (occ_ack) begin
                    occ_req_d = 1'b0;
                    if (!occ_hit) begin
                        food_d       = cand_q;
                        food_valid_d = 1'b1;
                        place_done_d = 1'b1;
                        state_d      = ST_COMMIT;
                    end else if (tries_left_s) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        place_fail_d = 1'b1;
                        state_d      = ST_FAIL;
                    end
                end else begin
                    state_d = ST_QUERY;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            ST_FAIL: begin
                state_d = ST_IDLE;
            end
            default: begin
                occ_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops occ_req and food_valid at once.
    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            state_q      <= ST_IDLE;
            tries_q      <= TRY_ZERO;
            cand_q       <= '0;
            occ_q        <= '0;
            food_q       <= '0;
            occ_req_q    <= 1'b0;
            food_valid_q <= 1'b0;
            place_done_q <= 1'b0;
            place_fail_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tries_q      <= tries_d;
            cand_q       <= cand_d;
            occ_q        <= occ_d;
            food_q       <= food_d;
            occ_req_q    <= occ_req_d;
            food_valid_q <= food_valid_d;
            place_done_q <= place_done_d;
            place_fail_q <= place_fail_d;
            busy_q       <= busy_d;
        end
    end

    assign occ_req    = occ_req_q;
    assign occ_x      = occ_q.col;
    assign occ_y      = occ_q.row;
    assign food_x     = food_q.col;
    assign food_y     = food_q.row;
    assign food_valid = food_valid_q;
    assign place_done = place_done_q;
    assign place_fail = place_fail_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_food_placer.sv
// Directed bench for food_placer with a bench-side occupancy responder whose
// ack delay and hit pattern are set per step.
module tb_food_placer;

    logic       clk1 = 1'b0;
    logic       rst1_n;
    logic       place_req;
    logic [9:0] rnd_x;
    logic [9:0] rnd_y;
    logic       occ_req;
    logic [5:0] occ_x;
    logic [5:0] occ_y;
    logic       occ_ack;
    logic       occ_hit;
    logic [5:0] food_x;
    logic [5:0] food_y;
    logic       food_valid;
    logic       place_done;
    logic       place_fail;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    int ack_delay = 0;
    int hit_mode  = 0;
    int wait_cnt  = 0;
    int n_req     = 0;
    int n_done    = 0;
    int n_fail    = 0;
    logic occ_req_prev = 1'b0;

    food_placer dut (
        .clk1       (clk1),
        .rst1_n     (rst1_n),
        .place_req  (place_req),
        .rnd_x      (rnd_x),
        .rnd_y      (rnd_y),
        .occ_req    (occ_req),
        .occ_x      (occ_x),
        .occ_y      (occ_y),
        .occ_ack    (occ_ack),
        .occ_hit    (occ_hit),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .place_done (place_done),
        .place_fail (place_fail),
        .busy       (busy)
    );

    always #5 clk1 = ~clk1;

    // Responder: ack after ack_delay cycles of occ_req; hit_mode 0 never hits,
    // 1 hits only cell (3,4), 2 always hits.
    assign occ_ack = occ_req && (wait_cnt == ack_delay);
    assign occ_hit = occ_ack && ((hit_mode == 2) ||
                                 ((hit_mode == 1) && (occ_x == 6'd3) && (occ_y == 6'd4)));

    always @(posedge clk1) begin
        if (!occ_req || occ_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    // Event counters for query starts and completion pulses.
    always @(posedge clk1) begin
        occ_req_prev <= occ_req;
        if (occ_req && !occ_req_prev) n_req <= n_req + 1;
        if (place_done) n_done <= n_done + 1;
        if (place_fail) n_fail <= n_fail + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_end(input int limit, output int cyc);
        cyc = 0;
        while (!(place_done || place_fail) && cyc < limit) begin
            @(negedge clk1);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int b_req;
        int b_done;
        int b_fail;

        rst1_n    = 1'b0;
        place_req = 1'b0;
        rnd_x     = 10'h000;
        rnd_y     = 10'h000;
        repeat (2) @(negedge clk1);

        check("rst_occ_req", occ_req, 1'b0);
        check("rst_occ_xy", {occ_x, occ_y}, 12'd0);
        check("rst_food_xy", {food_x, food_y}, 12'd0);
        check("rst_food_valid", food_valid, 1'b0);
        check("rst_pulses", {place_done, place_fail}, 2'b00);
        check("rst_busy", busy, 1'b0);
        rst1_n = 1'b1;
        @(negedge clk1);

        // Best case: zero-wait responder, free cell (15,15).
        ack_delay = 0;
        hit_mode  = 0;
        rnd_x     = 10'h00F;
        rnd_y     = 10'h00F;
        place_req = 1'b1;
        @(negedge clk1);
        place_req = 1'b0;
        check("t1_busy", busy, 1'b1);
        @(negedge clk1);
        @(negedge clk1);
        check("t1_occ_req", occ_req, 1'b1);
        check("t1_occ_x", occ_x, 6'd15);
        check("t1_occ_y", occ_y, 6'd15);
        @(negedge clk1);
        check("t1_done_lat4", place_done, 1'b1);
        check("t1_food", {food_x, food_y}, {6'd15, 6'd15});
        check("t1_food_valid", food_valid, 1'b1);
        @(negedge clk1);
        check("t1_done_pulse", place_done, 1'b0);
        check("t1_idle", busy, 1'b0);

        // Range rejection: row 48 rejected without a query, then (8,5).
        b_req = n_req;
        rnd_x = 10'h3C8;
        rnd_y = 10'h3F0;
        place_req = 1'b1;
        @(negedge clk1);
        place_req = 1'b0;
        @(negedge clk1);
        rnd_y = 10'h005;
        check("t2_no_req_first", occ_req, 1'b0);
        wait_end(30, cyc);
        check("t2_latency", 2 + cyc, 6);
        check("t2_done", place_done, 1'b1);
        check("t2_food", {food_x, food_y}, {6'd8, 6'd5});
        check("t2_req_count", n_req - b_req, 1);
        @(negedge clk1);

        // Occupancy retry with 3-cycle ack delay: (3,4) busy, (10,20) free.
        b_req     = n_req;
        ack_delay = 3;
        hit_mode  = 1;
        rnd_x     = 10'd3;
        rnd_y     = 10'd4;
        place_req = 1'b1;
        @(negedge clk1);
        place_req = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
        check("t3_occ_req", occ_req, 1'b1);
        check("t3_xy_w0", {occ_x, occ_y}, {6'd3, 6'd4});
        rnd_x = 10'd10;
        rnd_y = 10'd20;
        @(negedge clk1);
        check("t3_xy_w1", {occ_x, occ_y}, {6'd3, 6'd4});
        check("t3_no_ack_yet", occ_ack, 1'b0);
        @(negedge clk1);
        check("t3_xy_w2", {occ_x, occ_y}, {6'd3, 6'd4});
        @(negedge clk1);
        check("t3_ack", occ_ack, 1'b1);
        check("t3_xy_ack", {occ_x, occ_y}, {6'd3, 6'd4});
        wait_end(40, cyc);
        check("t3_latency", 6 + cyc, 13);
        check("t3_food", {food_x, food_y}, {6'd10, 6'd20});
        check("t3_req_count", n_req - b_req, 2);
        @(negedge clk1);

        // Exhaustion: prior food (1,2), then every query hits.
        ack_delay = 0;
        hit_mode  = 0;
        rnd_x     = 10'd1;
        rnd_y     = 10'd2;
        place_req = 1'b1;
        @(negedge clk1);
        place_req = 1'b0;
        wait_end(20, cyc);
        check("t4_prior_food", {food_x, food_y}, {6'd1, 6'd2});
        @(negedge clk1);
        hit_mode = 2;
        b_req  = n_req;
        b_done = n_done;
        b_fail = n_fail;
        place_req = 1'b1;
        @(negedge clk1);
        place_req = 1'b0;
        wait_end(300, cyc);
        check("t4_fail", place_fail, 1'b1);
        check("t4_food_kept", {food_x, food_y}, {6'd1, 6'd2});
        check("t4_valid_kept", food_valid, 1'b1);
        @(negedge clk1);
        check("t4_fail_pulse", place_fail, 1'b0);
        check("t4_queries", n_req - b_req, 16);
        check("t4_fail_count", n_fail - b_fail, 1);
        check("t4_no_done", n_done - b_done, 0);

        // place_req during QUERY and during COMMIT is ignored.
        ack_delay = 2;
        hit_mode  = 0;
        rnd_x     = 10'd7;
        rnd_y     = 10'd9;
        b_req  = n_req;
        b_done = n_done;
        place_req = 1'b1;
        @(negedge clk1);
        place_req = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
        check("t5_in_query", occ_req, 1'b1);
        place_req = 1'b1;
        @(negedge clk1);
        place_req = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
        check("t5_done", place_done, 1'b1);
        place_req = 1'b1;
        @(negedge clk1);
        place_req = 1'b0;
        repeat (10) @(negedge clk1);
        check("t5_done_count", n_done - b_done, 1);
        check("t5_req_count", n_req - b_req, 1);
        check("t5_idle", busy, 1'b0);
        check("t5_food", {food_x, food_y}, {6'd7, 6'd9});

        // Asynchronous reset while a query is outstanding.
        ack_delay = 5;
        rnd_x     = 10'd20;
        rnd_y     = 10'd30;
        place_req = 1'b1;
        @(negedge clk1);
        place_req = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
        check("t6_pre_req", occ_req, 1'b1);
        #2;
        rst1_n = 1'b0;
        #1;
        check("t6_async_req", occ_req, 1'b0);
        check("t6_async_valid", food_valid, 1'b0);
        check("t6_async_busy", busy, 1'b0);
        @(negedge clk1);
        rst1_n    = 1'b1;
        ack_delay = 0;
        place_req = 1'b1;
        @(negedge clk1);
        place_req = 1'b0;
        wait_end(20, cyc);
        check("t6_after_lat", 1 + cyc, 4);
        check("t6_after_done", place_done, 1'b1);
        check("t6_after_food", {food_x, food_y}, {6'd20, 6'd30});
        check("t6_after_valid", food_valid, 1'b1);
        @(negedge clk1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
